present80_round_ctrl: RTL and testbench

- Sequencing controller for the round-based, area-optimised PRESENT-80 encryption core.
- Drives load/update enables and mux selects for the 80-bit key register (enabled DFF, holds when enable=0) and the 64-bit state register.
- Generates the 5-bit round counter consumed by the key-schedule XOR.
- Provides a start/ready input handshake and a valid/ready output handshake to the surrounding system.

---
 rtl/present80_round_ctrl_pkg.sv | 68 ++++++
 rtl/present80_round_ctrl_round_cnt.sv | 30 +++
 rtl/present80_round_ctrl.sv | 122 ++++++++++++
 tb/tb_present80_round_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present80_round_ctrl_pkg.sv
// Shared types for the PRESENT-80 round controller: FSM states, register mux selects, control word.
// Optional key/state zeroisation after each block is enabled with PRESENT_KEY_ZEROIZE_EN.
package present_ctrl_pkg;

    localparam int unsigned ROUNDS_DEF = 31;
    localparam int unsigned RC_W_DEF   = 5;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned FSM_W      = 3;

    typedef enum logic [FSM_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        DONE  = 3'd3,
        ZERO  = 3'd4
    } fsm_e;

    typedef enum logic [SEL_W-1:0] {
        SEL_LOAD   = 2'd0,
        SEL_UPDATE = 2'd1,
        SEL_ZERO   = 2'd2
    } sel_e;

    typedef struct packed {
        logic ready;
        logic key_en;
        sel_e key_sel;
        logic state_en;
        sel_e state_sel;
        logic out_valid;
    } ctrl_t;

    // Moore decode of the control word for a given FSM state.
    function automatic ctrl_t decode(input fsm_e s);
        ctrl_t c;
        c.ready     = 1'b0;
        c.key_en    = 1'b0;
        c.key_sel   = SEL_LOAD;
        c.state_en  = 1'b0;
        c.state_sel = SEL_LOAD;
        c.out_valid = 1'b0;
        case (s)
            IDLE: c.ready = 1'b1;
            LOAD: begin
                c.key_en   = 1'b1;
                c.state_en = 1'b1;
            end
            ROUND: begin
                c.key_en    = 1'b1;
                c.key_sel   = SEL_UPDATE;
                c.state_en  = 1'b1;
                c.state_sel = SEL_UPDATE;
            end
            DONE: c.out_valid = 1'b1;
`ifdef PRESENT_KEY_ZEROIZE_EN
            ZERO: begin
                c.key_en    = 1'b1;
                c.key_sel   = SEL_ZERO;
                c.state_en  = 1'b1;
                c.state_sel = SEL_ZERO;
            end
`endif
            default: c.ready = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/present80_round_ctrl_round_cnt.sv
// Saturating round counter feeding the PRESENT key-schedule XOR; last flags cnt == ROUNDS.
module present_round_cnt
    import present_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEF,
    parameter int unsigned RC_W   = RC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            inc,
    input  logic            hold,
    output logic [RC_W-1:0] cnt,
    output logic            last
);

    assign last = (cnt == RC_W'(ROUNDS));

    // clear wins; the counter never advances past ROUNDS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !hold && !last) begin
            cnt <= cnt + RC_W'(1);
        end
    end

endmodule

// File: rtl/present80_round_ctrl.sv
// Sequencing controller for the round-based PRESENT-80 core (key/state enables, selects, round counter).
// Define PRESENT_KEY_ZEROIZE_EN to clear key and state registers for one cycle after each block or abort.
module present80_round_ctrl
    import present_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEF,
    parameter int unsigned RC_W   = RC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic             abort,
    output logic             key_en,
    output logic [SEL_W-1:0] key_sel,
    output logic             state_en,
    output logic [SEL_W-1:0] state_sel,
    output logic [RC_W-1:0]  round_cnt,
    output logic             out_valid,
    input  logic             out_ready
);

`ifdef PRESENT_KEY_ZEROIZE_EN
    localparam fsm_e EXIT_STATE = ZERO;
`else
    localparam fsm_e EXIT_STATE = IDLE;
`endif

    fsm_e  state_q;
    fsm_e  state_d;
    ctrl_t ctrl_q;
    ctrl_t ctrl_d;
    logic  cnt_clear;
    logic  cnt_inc;
    logic  cnt_hold;
    logic  cnt_last;

    present_round_cnt #(
        .ROUNDS (ROUNDS),
        .RC_W   (RC_W)
    ) u_round_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .hold  (cnt_hold),
        .cnt   (round_cnt),
        .last  (cnt_last)
    );

    // State and the control word decoded from the next state, so outputs come straight from flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= decode(IDLE);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        cnt_hold  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_inc = 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                cnt_inc  = 1'b1;
                cnt_hold = cnt_last;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_hold = 1'b1;
                if (out_ready) begin
                    state_d   = EXIT_STATE;
                    cnt_clear = 1'b1;
                end
            end
`ifdef PRESENT_KEY_ZEROIZE_EN
            ZERO: begin
                cnt_clear = 1'b1;
                state_d   = IDLE;
            end
`endif
            default: begin
                cnt_clear = 1'b1;
                state_d   = IDLE;
            end
        endcase

        // abort overrides both the handshake and the last-round transition
        if (abort && (state_q == LOAD || state_q == ROUND || state_q == DONE)) begin
            state_d   = EXIT_STATE;
            cnt_clear = 1'b1;
            cnt_inc   = 1'b0;
            cnt_hold  = 1'b0;
        end

        ctrl_d = decode(state_d);
    end

    assign ready     = ctrl_q.ready;
    assign key_en    = ctrl_q.key_en;
    assign key_sel   = ctrl_q.key_sel;
    assign state_en  = ctrl_q.state_en;
    assign state_sel = ctrl_q.state_sel;
    assign out_valid = ctrl_q.out_valid;

endmodule

// File: tb/tb_present80_round_ctrl.sv
// Bench for present80_round_ctrl: cycle-based controller model, attached PRESENT-80 datapath, reference cipher.
// Honours PRESENT_KEY_ZEROIZE_EN the same way as the design.
module tb_present80_round_ctrl;

    localparam int unsigned RC_W = 5;
`ifdef PRESENT_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic            out_ready;
    logic            ready;
    logic            key_en;
    logic            state_en;
    logic            out_valid;
    logic [1:0]      key_sel;
    logic [1:0]      state_sel;
    logic [RC_W-1:0] round_cnt;

    int checks = 0;
    int errors = 0;

    logic [79:0] key_in;
    logic [63:0] pt_in;
    logic [79:0] kr;
    logic [63:0] sr;

    always #5 clk = ~clk;

    present80_round_ctrl #(.ROUNDS(31), .RC_W(RC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .abort     (abort),
        .key_en    (key_en),
        .key_sel   (key_sel),
        .state_en  (state_en),
        .state_sel (state_sel),
        .round_cnt (round_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference PRESENT-80 ----------------
    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h21748FE3DA09B65C;
        return t[4*x +: 4];
    endfunction

    function automatic logic [63:0] rnd(input logic [63:0] s_in, input logic [63:0] rk);
        logic [63:0] s;
        logic [63:0] r;
        s = s_in ^ rk;
        for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
        r = '0;
        for (int i = 0; i < 63; i++) r[(16*i) % 63] = s[i];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [79:0] kupd(input logic [79:0] k_in, input logic [4:0] rc);
        logic [79:0] k;
        k = {k_in[18:0], k_in[79:19]};
        k[79:76] = sb(k[79:76]);
        k[19:15] = k[19:15] ^ rc;
        return k;
    endfunction

    function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
        logic [79:0] k;
        logic [63:0] s;
        k = key;
        s = pt;
        for (int i = 1; i <= 31; i++) begin
            s = rnd(s, k[79:16]);
            k = kupd(k, 5'(i));
        end
        return s ^ k[79:16];
    endfunction

    // Datapath registers driven only by the controller's enables/selects
    always @(posedge clk) begin
        if (key_en) begin
            case (key_sel)
                2'd0:    kr <= key_in;
                2'd1:    kr <= kupd(kr, round_cnt);
                default: kr <= '0;
            endcase
        end
        if (state_en) begin
            case (state_sel)
                2'd0:    sr <= pt_in;
                2'd1:    sr <= rnd(sr, kr[79:16]);
                default: sr <= '0;
            endcase
        end
    end

    // ---------------- controller model: cycles since acceptance ----------------
    int m_age;   // -1 idle, 1 load cycle, 2..32 rounds, 33 waiting with ciphertext
    bit m_zero;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age  <= -1;
            m_zero <= 1'b0;
        end else if (m_zero) begin
            m_zero <= 1'b0;
            m_age  <= -1;
        end else if (m_age < 0) begin
            if (start) m_age <= 1;
        end else if (abort || (m_age >= 33 && out_ready)) begin
            m_age  <= -1;
            m_zero <= ZEROIZE;
        end else if (m_age < 33) begin
            m_age <= m_age + 1;
        end
    end

    function automatic logic [12:0] model_out(input int age, input bit zero);
        logic       r, ke, se, ov;
        logic [1:0] ks, ss;
        logic [4:0] rc;
        r = 0; ke = 0; se = 0; ov = 0; ks = 0; ss = 0; rc = 0;
        if (zero) begin
            ke = 1; se = 1; ks = 2; ss = 2;
        end else if (age < 0) begin
            r = 1;
        end else if (age == 1) begin
            ke = 1; se = 1;
        end else if (age <= 32) begin
            ke = 1; se = 1; ks = 1; ss = 1; rc = 5'(age - 1);
        end else begin
            ov = 1; rc = 5'd31;
        end
        return {r, ke, ks, se, ss, rc, ov};
    endfunction

    always @(negedge clk) begin
        if (!rst)
            chk("outputs", 80'({ready, key_en, key_sel, state_en, state_sel, round_cnt, out_valid}),
                80'(model_out(m_age, m_zero)));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cnt(input int n);
        for (int i = 0; i < 60 && round_cnt != RC_W'(n); i++) step();
        chk("wait_round_cnt", 80'(round_cnt), 80'(n));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60 && !out_valid; i++) step();
        chk("wait_out_valid", 80'(out_valid), 80'(1));
    endtask

    task automatic after_handshake(input string tag);
        if (ZEROIZE) begin
            chk({tag, "_zero_cycle"}, 80'({ready, key_en, key_sel, state_en, state_sel}),
                80'({1'b0, 1'b1, 2'd2, 1'b1, 2'd2}));
            step();
            chk({tag, "_key_cleared"}, kr, 80'(0));
        end
        chk({tag, "_ready"}, 80'(ready), 80'(1));
    endtask

    // One block: latency/sequencing checks, optional backpressure stall, then handshake
    task automatic run_block(input logic [79:0] k, input logic [63:0] p, input int stall,
                             output logic [63:0] ct);
        int c, en_cnt, sel0, sel1;
        bit seq_ok;
        logic [79:0] held_k;
        logic [63:0] held_ct;
        key_in = k; pt_in = p; out_ready = (stall == 0);
        start = 1; step(); start = 0;
        c = 1; en_cnt = 0; sel0 = 0; sel1 = 0; seq_ok = 1;
        while (!out_valid && c < 60) begin
            if (key_en && state_en) en_cnt++;
            if (key_en && key_sel == 2'd0) sel0++;
            if (key_en && key_sel == 2'd1) sel1++;
            if (c >= 2 && round_cnt != RC_W'(c - 1)) seq_ok = 0;
            step();
            c++;
        end
        chk("latency", 80'(c), 80'(33));
        chk("enable_cycles", 80'(en_cnt), 80'(32));
        chk("load_sel_count", 80'(sel0), 80'(1));
        chk("update_sel_count", 80'(sel1), 80'(31));
        chk("round_cnt_sequence", 80'(seq_ok), 80'(1));
        ct = sr ^ kr[79:16];
        held_k = kr; held_ct = ct;
        for (int s = 0; s < stall; s++) begin
            start = ~s[0];
            step();
            chk("stall_valid", 80'({out_valid, ready}), 80'(2'b10));
            chk("stall_key_held", kr, held_k);
            chk("stall_ct_held", 80'(sr ^ kr[79:16]), 80'(held_ct));
        end
        start = 0;
        out_ready = 1;
        step();
        after_handshake("handshake");
    endtask

    logic [63:0] ct;
    int first_load, second_load;

    initial begin
        rst = 1; start = 0; abort = 0; out_ready = 1; key_in = '0; pt_in = '0;
        #12;
        chk("reset_outputs", 80'({ready, key_en, key_sel, state_en, state_sel, round_cnt, out_valid}),
            80'(13'b1_0_00_0_00_00000_0));
        rst = 0;
        step();

        chk("ref_zero_vector", 80'(present80(80'h0, 64'h0)), 80'(64'h5579C1387B228445));
        chk("ref_ones_vector", 80'(present80({80{1'b1}}, {64{1'b1}})), 80'(64'h3333DCD3213210D2));

        run_block(80'h0, 64'h0, 0, ct);
        chk("ct_zero", 80'(ct), 80'(64'h5579C1387B228445));

        run_block({80{1'b1}}, {64{1'b1}}, 10, ct);
        chk("ct_ones_backpressure", 80'(ct), 80'(64'h3333DCD3213210D2));

        run_block(80'h0123456789ABCDEF0123, 64'hDEADBEEFCAFEF00D, 0, ct);
        chk("ct_mixed", 80'(ct), 80'(present80(80'h0123456789ABCDEF0123, 64'hDEADBEEFCAFEF00D)));

        // asynchronous reset mid-round
        key_in = 80'h0; pt_in = 64'h0;
        start = 1; step(); start = 0;
        wait_cnt(12);
        #1 rst = 1;
        #1;
        chk("async_reset_ready", 80'(ready), 80'(1));
        chk("async_reset_cnt", 80'(round_cnt), 80'(0));
        chk("async_reset_enables", 80'({key_en, state_en, out_valid}), 80'(0));
        #2 rst = 0;
        step();

        // abort at round 20, then a fresh block with a new key
        key_in = 80'h0; pt_in = 64'h0;
        start = 1; step(); start = 0;
        wait_cnt(20);
        abort = 1; step(); abort = 0;
        chk("abort_no_valid", 80'(out_valid), 80'(0));
        after_handshake("abort");
        chk("abort_cnt_cleared", 80'(round_cnt), 80'(0));
        step();
        run_block({80{1'b1}}, {64{1'b1}}, 0, ct);
        chk("ct_after_abort", 80'(ct), 80'(64'h3333DCD3213210D2));

        // abort beats out_ready while waiting with a result
        key_in = 80'h5; pt_in = 64'h7; out_ready = 0;
        start = 1; step(); start = 0;
        wait_valid();
        abort = 1; out_ready = 1; step(); abort = 0;
        chk("abort_priority_valid", 80'(out_valid), 80'(0));
        after_handshake("abort_done");

        // back-to-back throughput with start held and out_ready tied high
        first_load = -1; second_load = -1;
        start = 1; out_ready = 1;
        for (int i = 0; i < 90 && second_load < 0; i++) begin
            step();
            if (key_en && key_sel == 2'd0) begin
                if (first_load < 0) first_load = i;
                else second_load = i;
            end
        end
        chk("throughput", 80'(second_load - first_load), 80'(ZEROIZE ? 35 : 34));
        start = 0;
        for (int i = 0; i < 60 && !ready; i++) step();
        chk("final_ready", 80'(ready), 80'(1));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
